// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-side branch predictor: BHT counter encodings and
// statistics counter limits.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_ctr_t;

    localparam bp_ctr_t     BP_RESET_CTR = BP_WNT;
    localparam logic [31:0] BP_CNT_MAX   = '1;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] bp_sat_inc(input logic [31:0] val, input logic inc);
        return (inc && val != BP_CNT_MAX) ? val + 32'd1 : val;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup/update/statistics bundle between fetch, EX and the branch predictor.
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_pred_taken;
    logic [XLEN-1:0] upd_pred_tgt;
    logic            mispredict;
    logic [31:0]     br_count;
    logic [31:0]     mp_count;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_tgt,
        input  pred_taken, pred_target, mispredict, br_count, mp_count
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_tgt,
        output pred_taken, pred_target, mispredict, br_count, mp_count
    );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// 2-bit saturating next-state function for one BHT entry.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  bp_ctr_t ctr,
    input  logic    taken,
    output bp_ctr_t ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != BP_ST) ctr_next = bp_ctr_t'(ctr + 2'd1);
        end else begin
            if (ctr != BP_SNT) ctr_next = bp_ctr_t'(ctr - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT of 2-bit counters plus tagged BTB; zero-latency lookup,
// trained by EX resolution, with branch/mispredict statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = 6,
    parameter int XLEN     = 32
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bus
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = XLEN - IDX_BITS - 2;

    bp_ctr_t         bht        [ENTRIES];
    logic            btb_valid  [ENTRIES];
    logic [TAG_W-1:0] btb_tag   [ENTRIES];
    logic [XLEN-1:0] btb_target [ENTRIES];

    logic [IDX_BITS-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]    lk_tag, up_tag;
    logic                lk_hit;
    bp_ctr_t             ctr_next;
    logic [31:0]         br_cnt_q, mp_cnt_q;

    assign lk_idx = bus.if_pc[IDX_BITS+1:2];
    assign lk_tag = bus.if_pc[XLEN-1:IDX_BITS+2];
    assign up_idx = bus.upd_pc[IDX_BITS+1:2];
    assign up_tag = bus.upd_pc[XLEN-1:IDX_BITS+2];

    // Lookup reads current state only; a same-cycle update is seen next cycle.
    assign lk_hit          = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    assign bus.pred_taken  = lk_hit && bht[lk_idx][1];
    assign bus.pred_target = bus.pred_taken ? btb_target[lk_idx] : bus.if_pc + XLEN'(4);

    assign bus.mispredict = bus.upd_valid &&
                            ((bus.upd_taken != bus.upd_pred_taken) ||
                             (bus.upd_taken && (bus.upd_pred_tgt != bus.upd_target)));

    assign bus.br_count = br_cnt_q;
    assign bus.mp_count = mp_cnt_q;

    bp_sat_counter u_ctr (
        .ctr      (bht[up_idx]),
        .taken    (bus.upd_taken),
        .ctr_next (ctr_next)
    );

    // Tag/target storage is qualified by btb_valid, so only the valid bits need reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                bht[i]       <= BP_RESET_CTR;
                btb_valid[i] <= 1'b0;
            end
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else if (bus.upd_valid) begin
            bht[up_idx] <= ctr_next;
            if (bus.upd_taken) begin
                btb_valid[up_idx]  <= 1'b1;
                btb_tag[up_idx]    <= up_tag;
                btb_target[up_idx] <= bus.upd_target;
            end
            br_cnt_q <= bp_sat_inc(br_cnt_q, 1'b1);
            mp_cnt_q <= bp_sat_inc(mp_cnt_q, bus.mispredict);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expectations are queued as stimulus is
// driven and compared against the DUT once outputs have settled.
module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    typedef enum int {S_PT, S_PTGT, S_MP, S_BR, S_MPC} sel_t;
    typedef struct {
        string       tag;
        sel_t        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(32)) bus ();

    branch_predictor #(.IDX_BITS(6), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input sel_t sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Compare every queued expectation against the settled DUT outputs.
    task automatic drain();
        exp_t        e;
        logic [31:0] got;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                S_PT:    got = {31'd0, bus.pred_taken};
                S_PTGT:  got = bus.pred_target;
                S_MP:    got = {31'd0, bus.mispredict};
                S_BR:    got = bus.br_count;
                default: got = bus.mp_count;
            endcase
            check(e.tag, got, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_t_, input logic [31:0] exp_tgt);
        bus.if_pc = pc;
        push({tag, "_pt"}, S_PT, {31'd0, exp_t_});
        push({tag, "_tgt"}, S_PTGT, exp_tgt);
        drain();
    endtask

    task automatic counts(input string tag, input logic [31:0] br, input logic [31:0] mp);
        push({tag, "_br"}, S_BR, br);
        push({tag, "_mp"}, S_MPC, mp);
        drain();
    endtask

    // Drive one resolved branch, check mispredict in the same cycle, then clock it in.
    task automatic update(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt, input logic exp_mp);
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = pc;
        bus.upd_taken      = tk;
        bus.upd_target     = tgt;
        bus.upd_pred_taken = ptk;
        bus.upd_pred_tgt   = ptgt;
        push({tag, "_mispredict"}, S_MP, {31'd0, exp_mp});
        drain();
        tick();
        bus.upd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.if_pc = '0;
        bus.upd_valid = 1'b0;
        bus.upd_pc = '0;
        bus.upd_taken = 1'b0;
        bus.upd_target = '0;
        bus.upd_pred_taken = 1'b0;
        bus.upd_pred_tgt = '0;
        tick();
        do_reset();

        // Reset state: every PC predicts fall-through.
        counts("rst", 32'd0, 32'd0);
        for (int pc = 0; pc <= 'hFC; pc += 4)
            lookup("sweep", 32'(pc), 1'b0, 32'(pc + 4));

        // First taken update at 0x40 (counter 01 -> 10).
        update("t2", 32'h40, 1'b1, 32'h80, 1'b0, 32'h44, 1'b1);
        lookup("t2", 32'h40, 1'b1, 32'h80);
        counts("t2", 32'd1, 32'd1);

        // Saturate up, then walk down: predictions before each not-taken are 1,1,0.
        update("t3_up1", 32'h40, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
        update("t3_up2", 32'h40, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
        lookup("t3_pre1", 32'h40, 1'b1, 32'h80);
        update("t3_nt1", 32'h40, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1);
        lookup("t3_pre2", 32'h40, 1'b1, 32'h80);
        update("t3_nt2", 32'h40, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1);
        lookup("t3_pre3", 32'h40, 1'b0, 32'h44);
        update("t3_nt3", 32'h40, 1'b0, 32'h80, 1'b0, 32'h44, 1'b0);
        lookup("t3_snt", 32'h40, 1'b0, 32'h44);
        update("t3_tk", 32'h40, 1'b1, 32'h80, 1'b0, 32'h44, 1'b1);
        lookup("t3_wnt", 32'h40, 1'b0, 32'h44);
        counts("t3", 32'd7, 32'd4);

        // Aliasing: 0x40 and 0x140 share index 16 with different tags.
        update("t4_a", 32'h40, 1'b1, 32'h80, 1'b0, 32'h44, 1'b1);
        lookup("t4_40", 32'h40, 1'b1, 32'h80);
        lookup("t4_140miss", 32'h140, 1'b0, 32'h144);
        update("t4_b", 32'h140, 1'b1, 32'h200, 1'b0, 32'h144, 1'b1);
        lookup("t4_40miss", 32'h40, 1'b0, 32'h44);
        lookup("t4_140hit", 32'h140, 1'b1, 32'h200);
        counts("t4", 32'd9, 32'd6);

        // Same-cycle lookup/update: no bypass; also a target-only mispredict.
        do_reset();
        bus.if_pc = 32'h40;
        push("t5_same_pt", S_PT, 32'd0);
        push("t5_same_tgt", S_PTGT, 32'h44);
        update("t5", 32'h40, 1'b1, 32'h80, 1'b1, 32'h84, 1'b1);
        lookup("t5_next", 32'h40, 1'b1, 32'h80);
        counts("t5", 32'd1, 32'd1);
        push("t5_idle_mispredict", S_MP, 32'd0);
        drain();

        // Mid-run reset swallows the concurrent update.
        update("t6_pre", 32'h80, 1'b1, 32'h100, 1'b0, 32'h84, 1'b1);
        lookup("t6_pre80", 32'h80, 1'b1, 32'h100);
        rst = 1'b1;
        bus.upd_valid = 1'b1;
        bus.upd_pc = 32'hC0;
        bus.upd_taken = 1'b1;
        bus.upd_target = 32'h300;
        bus.upd_pred_taken = 1'b0;
        bus.upd_pred_tgt = 32'hC4;
        tick();
        rst = 1'b0;
        bus.upd_valid = 1'b0;
        counts("t6", 32'd0, 32'd0);
        lookup("t6_40", 32'h40, 1'b0, 32'h44);
        lookup("t6_80", 32'h80, 1'b0, 32'h84);
        lookup("t6_c0", 32'hC0, 1'b0, 32'hC4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
